// File: rtl/board_pkg.sv
// Shared types for the game board writer and the pixel renderer that consumes the board.
package board_pkg;

    localparam int ROWS_C   = 10;
    localparam int COLS_C   = 10;
    localparam int CELL_W_C = 12;

    typedef logic [CELL_W_C-1:0] cell_t;
    // Row index first, column index second; row ROWS_C-1 is the bottom of the board.
    typedef cell_t board_t [ROWS_C][COLS_C];

    typedef enum logic {
        OP_DROP  = 1'b0,
        OP_CLEAR = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_COL_FULL  = 2'd1,
        ST_BAD_COL   = 2'd2,
        ST_BAD_VALUE = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        WRITE = 3'd2,
        CLEAR = 3'd3,
        RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/board_writer.sv
// Command-driven board writer: gravity drops and full clears, committed only in vertical blank
// so the renderer never observes a half-updated board.
module board_writer
    import board_pkg::*;
#(
    parameter int ROWS        = ROWS_C,
    parameter int COLS        = COLS_C,
    parameter int CELL_W      = CELL_W_C,
    parameter int SYNC_VBLANK = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vblank,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [3:0]        cmd_col,
    input  logic [CELL_W-1:0] cmd_value,
    output logic              rsp_valid,
    output logic [1:0]        rsp_status,
    output logic [3:0]        rsp_row,
    output logic [6:0]        piece_count,
    output logic [CELL_W-1:0] matrixGame [ROWS][COLS]
);

    localparam int         MAX_PIECES = ROWS * COLS;
    localparam logic [3:0] LAST_ROW   = 4'(ROWS - 1);

    state_e            state_q, state_d;
    logic [3:0]        row_ptr_q, row_ptr_d;
    logic [3:0]        col_q, col_d;
    logic [CELL_W-1:0] value_q, value_d;
    status_e           rsp_status_q, rsp_status_d;
    logic [3:0]        rsp_row_q, rsp_row_d;
    logic [6:0]        count_q, count_d;
    logic [CELL_W-1:0] board_q [ROWS][COLS];

    logic              wr_en, clr_en, commit_ok, cell_empty;
    logic [ROWS-1:0]   row_sel;

    assign commit_ok  = (SYNC_VBLANK == 0) || vblank;
    assign cell_empty = (board_q[row_ptr_q][col_q] == '0);

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_sel
        assign row_sel[gi] = (row_ptr_q == 4'(gi));
    end

    always_comb begin
        state_d      = state_q;
        row_ptr_d    = row_ptr_q;
        col_d        = col_q;
        value_d      = value_q;
        rsp_status_d = rsp_status_q;
        rsp_row_d    = rsp_row_q;
        count_d      = count_q;
        wr_en        = 1'b0;
        clr_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    col_d   = cmd_col;
                    value_d = cmd_value;
                    if (op_e'(cmd_op) == OP_CLEAR) begin
                        state_d   = CLEAR;
                        row_ptr_d = '0;
                    end else if (int'(cmd_col) >= COLS) begin
                        state_d      = RESP;
                        rsp_status_d = ST_BAD_COL;
                        rsp_row_d    = '0;
                    end else if (cmd_value == '0) begin
                        state_d      = RESP;
                        rsp_status_d = ST_BAD_VALUE;
                        rsp_row_d    = '0;
                    end else begin
                        state_d   = SCAN;
                        row_ptr_d = LAST_ROW;
                    end
                end
            end
            // Walk upward from the bottom until the first empty cell of the column.
            SCAN: begin
                if (cell_empty) begin
                    state_d = WRITE;
                end else if (row_ptr_q == '0) begin
                    state_d      = RESP;
                    rsp_status_d = ST_COL_FULL;
                    rsp_row_d    = '0;
                end else begin
                    row_ptr_d = row_ptr_q - 4'd1;
                end
            end
            WRITE: begin
                if (commit_ok) begin
                    wr_en        = 1'b1;
                    rsp_status_d = ST_OK;
                    rsp_row_d    = row_ptr_q;
                    state_d      = RESP;
                    if (int'(count_q) < MAX_PIECES) begin
                        count_d = count_q + 7'd1;
                    end
                end
            end
            CLEAR: begin
                if (commit_ok) begin
                    clr_en = 1'b1;
                    if (row_ptr_q == LAST_ROW) begin
                        count_d      = '0;
                        rsp_status_d = ST_OK;
                        rsp_row_d    = '0;
                        state_d      = RESP;
                    end else begin
                        row_ptr_d = row_ptr_q + 4'd1;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_ptr_q    <= '0;
            col_q        <= '0;
            value_q      <= '0;
            rsp_status_q <= ST_OK;
            rsp_row_q    <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            row_ptr_q    <= row_ptr_d;
            col_q        <= col_d;
            value_q      <= value_d;
            rsp_status_q <= rsp_status_d;
            rsp_row_q    <= rsp_row_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    board_q[r][c] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (clr_en && row_sel[r]) begin
                        board_q[r][c] <= '0;
                    end else if (wr_en && row_sel[r] && (col_q == 4'(c))) begin
                        board_q[r][c] <= value_q;
                    end
                end
            end
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_status  = rsp_status_q;
    assign rsp_row     = rsp_row_q;
    assign piece_count = count_q;
    assign matrixGame  = board_q;

endmodule

// File: tb/tb_board_writer.sv
// Directed bench for board_writer: drops, column-full, bad commands, vblank gating, clear, reset abort.
module tb_board_writer;
    import board_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, vblank, cmd_valid, cmd_op, cmd_ready, rsp_valid;
    logic [3:0] cmd_col, rsp_row;
    cell_t      cmd_value;
    logic [1:0] rsp_status;
    logic [6:0] piece_count;
    cell_t      matrixGame [ROWS_C][COLS_C];

    board_t exp_board;
    int     exp_count   = 0;
    int     vectors     = 0;
    int     miscompares = 0;

    always #5 clk = ~clk;

    board_writer #(.ROWS(ROWS_C), .COLS(COLS_C), .CELL_W(CELL_W_C), .SYNC_VBLANK(1)) dut (
        .clk(clk), .rst_n(rst_n), .vblank(vblank),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_col(cmd_col), .cmd_value(cmd_value),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_row(rsp_row),
        .piece_count(piece_count), .matrixGame(matrixGame)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int board_diff();
        int n = 0;
        for (int r = 0; r < ROWS_C; r++)
            for (int c = 0; c < COLS_C; c++)
                if (matrixGame[r][c] !== exp_board[r][c]) n++;
        return n;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < ROWS_C; r++)
            for (int c = 0; c < COLS_C; c++)
                exp_board[r][c] = '0;
        exp_count = 0;
    endtask

    // Wait for ready, present one command for one accept edge, then time the response.
    task automatic do_cmd(input string tag, input logic op, input logic [3:0] col, input cell_t val,
                          input int exp_lat, input logic [1:0] exp_st, input logic [3:0] exp_row);
        int guard = 0;
        int lat;
        while (!cmd_ready && guard < 200) begin tick(); guard++; end
        chk({tag, " ready"}, 32'(cmd_ready), 1);
        cmd_op = op; cmd_col = col; cmd_value = val; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin tick(); lat++; end
        $display("cmd %s op=%0d col=%0d val=%0h -> lat=%0d status=%0d row=%0d count=%0d",
                 tag, op, col, val, lat, rsp_status, rsp_row, piece_count);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " status"}, 32'(rsp_status), 32'(exp_st));
        chk({tag, " row"}, 32'(rsp_row), 32'(exp_row));
        tick();
        chk({tag, " pulse end"}, 32'(rsp_valid), 0);
        chk({tag, " ready after"}, 32'(cmd_ready), 1);
    endtask

    // Successful drop: expected row/latency are hand-computed by the caller.
    task automatic drop_ok(input string tag, input logic [3:0] col, input cell_t val,
                           input logic [3:0] row, input int lat);
        do_cmd(tag, 1'b0, col, val, lat, 2'd0, row);
        exp_board[row][col] = val;
        exp_count++;
        chk({tag, " board"}, board_diff(), 0);
        chk({tag, " count"}, 32'(piece_count), exp_count);
    endtask

    initial begin
        int bad;
        int ptr;
        rst_n = 1'b0; vblank = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0;
        cmd_col = '0; cmd_value = '0;
        model_clear();

        // Reset state
        repeat (3) tick();
        chk("reset count", 32'(piece_count), 0);
        chk("reset rsp_valid", 32'(rsp_valid), 0);
        chk("reset status", 32'(rsp_status), 0);
        chk("reset row", 32'(rsp_row), 0);
        chk("reset ready", 32'(cmd_ready), 1);
        chk("reset board", board_diff(), 0);
        rst_n = 1'b1;
        tick();

        // Single drop into empty column 3
        drop_ok("drop c3", 4'd3, 12'h001, 4'd9, 3);

        // Stacking in column 0: k occupied cells -> latency 3+k
        drop_ok("c0 #1", 4'd0, 12'h001, 4'd9, 3);
        drop_ok("c0 #2", 4'd0, 12'h002, 4'd8, 4);
        drop_ok("c0 #3", 4'd0, 12'h001, 4'd7, 5);
        drop_ok("c0 #4", 4'd0, 12'h002, 4'd6, 6);

        // Fill column 5, then overflow it
        for (int i = 0; i < 10; i++)
            drop_ok("c5 fill", 4'd5, cell_t'(12'h050 + i), 4'(9 - i), 3 + i);
        do_cmd("c5 full", 1'b0, 4'd5, 12'h0AA, 11, 2'd1, 4'd0);
        chk("c5 full board", board_diff(), 0);
        chk("c5 full count", 32'(piece_count), 15);

        // Bad commands; bad column wins over bad value
        do_cmd("bad col", 1'b0, 4'd10, 12'h001, 1, 2'd2, 4'd0);
        do_cmd("bad value", 1'b0, 4'd2, 12'h000, 1, 2'd3, 4'd0);
        do_cmd("bad both", 1'b0, 4'd15, 12'h000, 1, 2'd2, 4'd0);
        chk("bad board", board_diff(), 0);
        chk("bad count", 32'(piece_count), 15);

        // Write held off by active video
        vblank = 1'b0;
        cmd_op = 1'b0; cmd_col = 4'd1; cmd_value = 12'h007; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        bad = 0;
        repeat (50) begin
            tick();
            if (matrixGame[9][1] !== 12'h000 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) bad++;
        end
        chk("hold in write", bad, 0);
        vblank = 1'b1;
        tick();
        $display("cmd vblank-gated drop col=1 -> cell=%0h rsp_valid=%0d row=%0d",
                 matrixGame[9][1], rsp_valid, rsp_row);
        chk("gated write cell", 32'(matrixGame[9][1]), 32'h007);
        chk("gated rsp_valid", 32'(rsp_valid), 1);
        chk("gated status", 32'(rsp_status), 0);
        chk("gated row", 32'(rsp_row), 9);
        exp_board[9][1] = 12'h007;
        exp_count++;
        chk("gated count", 32'(piece_count), exp_count);
        tick();
        chk("gated pulse end", 32'(rsp_valid), 0);

        // Clear with vblank toggling: rows advance only on vblank-high cycles
        cmd_op = 1'b1; cmd_col = 4'd0; cmd_value = '0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        ptr = 0;
        for (int cyc = 0; cyc < 40 && ptr < ROWS_C; cyc++) begin
            vblank = cyc[0];
            tick();
            if (vblank) begin
                for (int c = 0; c < COLS_C; c++) exp_board[ptr][c] = '0;
                ptr++;
            end
            chk("clear progress", board_diff(), 0);
            if (ptr < ROWS_C) chk("clear no rsp", 32'(rsp_valid), 0);
        end
        $display("cmd clear -> rsp_valid=%0d status=%0d row=%0d count=%0d",
                 rsp_valid, rsp_status, rsp_row, piece_count);
        chk("clear rsp_valid", 32'(rsp_valid), 1);
        chk("clear status", 32'(rsp_status), 0);
        chk("clear row", 32'(rsp_row), 0);
        chk("clear count", 32'(piece_count), 0);
        exp_count = 0;
        vblank = 1'b1;
        tick();
        chk("clear pulse end", 32'(rsp_valid), 0);

        // Reset asserted mid-scan aborts the command
        drop_ok("c4 #1", 4'd4, 12'h003, 4'd9, 3);
        drop_ok("c4 #2", 4'd4, 12'h004, 4'd8, 4);
        cmd_op = 1'b0; cmd_col = 4'd4; cmd_value = 12'h005; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("abort ready", 32'(cmd_ready), 1);
        chk("abort rsp_valid", 32'(rsp_valid), 0);
        chk("abort board", board_diff(), 0);
        chk("abort count", 32'(piece_count), 0);
        chk("abort row", 32'(rsp_row), 0);
        chk("abort status", 32'(rsp_status), 0);
        bad = 0;
        repeat (2) begin tick(); if (rsp_valid !== 1'b0) bad++; end
        rst_n = 1'b1;
        repeat (6) begin tick(); if (rsp_valid !== 1'b0 || board_diff() != 0) bad++; end
        $display("cmd reset during scan -> spurious events=%0d", bad);
        chk("abort quiet", bad, 0);
        drop_ok("post reset", 4'd4, 12'h005, 4'd9, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
